// File: rtl/sram_axi_arbiter_if.sv
// AXI-lite bundle shared by the IFU, LSU and SRAM sides of the arbiter.
// The master modport is the requester's view and the slave modport is the responder's view.
interface sram_axi_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          arvalid;
  logic [AW-1:0] araddr;
  logic          arready;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rready;
  logic          awvalid;
  logic [AW-1:0] awaddr;
  logic          awready;
  logic          wvalid;
  logic [DW-1:0] wdata;
  logic [7:0]    wstrb;
  logic          wready;
  logic          bvalid;
  logic [1:0]    bresp;
  logic          bready;

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/sram_axi_arbiter.sv
// Two-master AXI-lite arbiter in front of the SRAM. M0 (IFU) only reads; M1 (LSU) reads and writes.
// One transaction is in flight at a time, and contention is settled round-robin.
module sram_axi_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                rst,
  sram_axi_arbiter_if.slave   m0_if,
  sram_axi_arbiter_if.slave   m1_if,
  sram_axi_arbiter_if.master  s_if,
  output logic [1:0]          grant_o
);

  // The state encoding doubles as the grant code.
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] M0_RD = 2'b01;
  localparam logic [1:0] M1_RD = 2'b10;
  localparam logic [1:0] M1_WR = 2'b11;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic       m0_req_s, m1_req_s;
  logic       unused_s;

  assign m0_req_s = m0_if.arvalid;
  assign m1_req_s = m1_if.awvalid | m1_if.arvalid;
  assign grant_o  = state_q;
  assign unused_s = ^{m0_if.awvalid, m0_if.awaddr, m0_if.wvalid, m0_if.wdata,
                      m0_if.wstrb, m0_if.bready};

  // State and last-served register. last_q = 1 means M1 was served last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Arbitration happens in IDLE only; a grant is released on its response handshake.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_req_s && (!m1_req_s || last_q)) begin
          state_d = M0_RD;
          last_d  = 1'b0;
        end else if (m1_req_s) begin
          state_d = m1_if.awvalid ? M1_WR : M1_RD;
          last_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      M0_RD: begin
        if (s_if.rvalid && m0_if.rready) state_d = IDLE;
        else                             state_d = M0_RD;
      end
      M1_RD: begin
        if (s_if.rvalid && m1_if.rready) state_d = IDLE;
        else                             state_d = M1_RD;
      end
      M1_WR: begin
        if (s_if.bvalid && m1_if.bready) state_d = IDLE;
        else                             state_d = M1_WR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel routing: the granted master is wired straight to the SRAM, and everything else is held at zero.
  always_comb begin
    m0_if.arready = 1'b0;
    m0_if.rvalid  = 1'b0;
    m0_if.rdata   = '0;
    m0_if.rresp   = 2'b00;
    m0_if.awready = 1'b0;
    m0_if.wready  = 1'b0;
    m0_if.bvalid  = 1'b0;
    m0_if.bresp   = 2'b00;
    m1_if.arready = 1'b0;
    m1_if.rvalid  = 1'b0;
    m1_if.rdata   = '0;
    m1_if.rresp   = 2'b00;
    m1_if.awready = 1'b0;
    m1_if.wready  = 1'b0;
    m1_if.bvalid  = 1'b0;
    m1_if.bresp   = 2'b00;
    s_if.arvalid  = 1'b0;
    s_if.araddr   = '0;
    s_if.rready   = 1'b0;
    s_if.awvalid  = 1'b0;
    s_if.awaddr   = '0;
    s_if.wvalid   = 1'b0;
    s_if.wdata    = '0;
    s_if.wstrb    = 8'h00;
    s_if.bready   = 1'b0;
    case (state_q)
      M0_RD: begin
        s_if.arvalid  = m0_if.arvalid;
        s_if.araddr   = m0_if.araddr;
        s_if.rready   = m0_if.rready;
        m0_if.arready = s_if.arready;
        m0_if.rvalid  = s_if.rvalid;
        m0_if.rdata   = s_if.rdata;
        m0_if.rresp   = s_if.rresp;
      end
      M1_RD: begin
        s_if.arvalid  = m1_if.arvalid;
        s_if.araddr   = m1_if.araddr;
        s_if.rready   = m1_if.rready;
        m1_if.arready = s_if.arready;
        m1_if.rvalid  = s_if.rvalid;
        m1_if.rdata   = s_if.rdata;
        m1_if.rresp   = s_if.rresp;
      end
      M1_WR: begin
        s_if.awvalid  = m1_if.awvalid;
        s_if.awaddr   = m1_if.awaddr;
        s_if.wvalid   = m1_if.wvalid;
        s_if.wdata    = m1_if.wdata;
        s_if.wstrb    = m1_if.wstrb;
        s_if.bready   = m1_if.bready;
        m1_if.awready = s_if.awready;
        m1_if.wready  = s_if.wready;
        m1_if.bvalid  = s_if.bvalid;
        m1_if.bresp   = s_if.bresp;
      end
      default: begin
        s_if.arvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Bench for sram_axi_arbiter. It contains an SRAM responder with random latency and a reference memory
// updated from the masters' side. A per-cycle monitor checks grant order and channel isolation.
module tb_sram_axi_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  int         total = 0;
  int         bad = 0;
  bit         hold_slave = 1'b0;
  logic [31:0] sram_mem [8];
  logic [31:0] ref_mem  [8];

  always #5 clk = ~clk;

  sram_axi_arbiter_if m0_bus ();
  sram_axi_arbiter_if m1_bus ();
  sram_axi_arbiter_if s_bus ();

  sram_axi_arbiter dut (
    .clk(clk), .rst(rst), .m0_if(m0_bus), .m1_if(m1_bus), .s_if(s_bus), .grant_o(grant)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input logic [2:0] idx);
    return {1'b1, 26'd0, idx, 2'b00};
  endfunction

  // The monitor predicts each grant from the requests it saw pending and the master served last.
  logic [1:0] p_g = 2'b00;
  bit p_m0 = 1'b0, p_m1 = 1'b0, p_aw = 1'b0, p_exit = 1'b0, last_m1 = 1'b1;
  always @(negedge clk) begin : mon
    logic [1:0] eg;
    logic [5:0] leak;
    bit win0;
    if (rst) begin
      last_m1 = 1'b1;
    end else begin
      if (p_g == 2'b00) begin
        if (p_m0 && p_m1) win0 = last_m1;
        else              win0 = p_m0;
        if (!p_m0 && !p_m1) eg = 2'b00;
        else if (win0)      eg = 2'b01;
        else                eg = p_aw ? 2'b11 : 2'b10;
      end else begin
        eg = p_exit ? 2'b00 : p_g;
      end
      check_val("grant", 64'(grant), 64'(eg));
      if (p_g == 2'b00 && grant != 2'b00) last_m1 = (grant != 2'b01);
      leak[0] = (grant != 2'b01) & (m0_bus.arready | m0_bus.rvalid | (|m0_bus.rdata) | (|m0_bus.rresp));
      leak[1] = (grant != 2'b10) & (m1_bus.arready | m1_bus.rvalid | (|m1_bus.rdata) | (|m1_bus.rresp));
      leak[2] = (grant != 2'b11) & (m1_bus.awready | m1_bus.wready | m1_bus.bvalid | (|m1_bus.bresp));
      leak[3] = (grant == 2'b00 || grant == 2'b11) & (s_bus.arvalid | s_bus.rready | (|s_bus.araddr));
      leak[4] = (grant != 2'b11) & (s_bus.awvalid | s_bus.wvalid | s_bus.bready | (|s_bus.awaddr)
                                   | (|s_bus.wdata) | (|s_bus.wstrb));
      leak[5] = m0_bus.awready | m0_bus.wready | m0_bus.bvalid;
      check_val("isolation", 64'(leak), 64'd0);
    end
    p_g    = rst ? 2'b00 : grant;
    p_m0   = m0_bus.arvalid;
    p_m1   = m1_bus.arvalid | m1_bus.awvalid;
    p_aw   = m1_bus.awvalid;
    p_exit = (grant == 2'b01 && s_bus.rvalid && m0_bus.rready) ||
             (grant == 2'b10 && s_bus.rvalid && m1_bus.rready) ||
             (grant == 2'b11 && s_bus.bvalid && m1_bus.bready);
  end

  // SRAM responder: serves one read or one write at a time with random latencies.
  initial begin : sram
    int n;
    logic [2:0] idx;
    s_bus.arready = 1'b0; s_bus.rvalid = 1'b0; s_bus.rdata = 32'd0; s_bus.rresp = 2'b00;
    s_bus.awready = 1'b0; s_bus.wready = 1'b0; s_bus.bvalid = 1'b0; s_bus.bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst && !hold_slave && s_bus.arvalid) begin
        @(posedge clk); #1;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        s_bus.arready = 1'b1;
        idx = s_bus.araddr[4:2];
        @(posedge clk); #1;
        s_bus.arready = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        s_bus.rvalid = 1'b1;
        s_bus.rdata  = sram_mem[idx];
        s_bus.rresp  = (idx == 3'd7) ? 2'b10 : 2'b00;
        n = 0;
        @(negedge clk);
        while (!s_bus.rready && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        s_bus.rvalid = 1'b0; s_bus.rdata = 32'd0; s_bus.rresp = 2'b00;
      end else if (!rst && !hold_slave && s_bus.awvalid && s_bus.wvalid) begin
        @(posedge clk); #1;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        s_bus.awready = 1'b1;
        s_bus.wready  = 1'b1;
        idx = s_bus.awaddr[4:2];
        for (int b = 0; b < 4; b++)
          if (s_bus.wstrb[b]) sram_mem[idx][8*b +: 8] = s_bus.wdata[8*b +: 8];
        @(posedge clk); #1;
        s_bus.awready = 1'b0;
        s_bus.wready  = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        s_bus.bvalid = 1'b1;
        s_bus.bresp  = (idx == 3'd6) ? 2'b10 : 2'b00;
        n = 0;
        @(negedge clk);
        while (!s_bus.bready && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        s_bus.bvalid = 1'b0; s_bus.bresp = 2'b00;
      end
    end
  end

  // Address handshake, then data handshake. The caller has already raised arvalid.
  task automatic rd_phase(input bit sel, input logic [2:0] idx, input int rdly);
    bit hs, rv, rr;
    int n;
    logic [31:0] d;
    logic [1:0] rs;
    string nm;
    nm = sel ? "m1" : "m0";
    hs = 1'b0; n = 0;
    while (!hs && n < 300) begin
      @(negedge clk);
      hs = sel ? (m1_bus.arvalid && m1_bus.arready) : (m0_bus.arvalid && m0_bus.arready);
      @(posedge clk); #1; n++;
    end
    check_val({nm, "_ar_hs"}, 64'(hs), 64'd1);
    if (sel) begin m1_bus.arvalid = 1'b0; m1_bus.araddr = 32'd0; end
    else     begin m0_bus.arvalid = 1'b0; m0_bus.araddr = 32'd0; end
    hs = 1'b0; n = 0;
    while (!hs && n < 300) begin
      if (n >= rdly) begin
        if (sel) m1_bus.rready = 1'b1;
        else     m0_bus.rready = 1'b1;
      end
      @(negedge clk);
      rv = sel ? m1_bus.rvalid : m0_bus.rvalid;
      rr = sel ? m1_bus.rready : m0_bus.rready;
      d  = sel ? m1_bus.rdata  : m0_bus.rdata;
      rs = sel ? m1_bus.rresp  : m0_bus.rresp;
      if (rv && rr) begin
        hs = 1'b1;
        check_val({nm, "_rdata"}, 64'(d), 64'(ref_mem[idx]));
        check_val({nm, "_rresp"}, 64'(rs), (idx == 3'd7) ? 64'd2 : 64'd0);
      end
      @(posedge clk); #1; n++;
    end
    m0_bus.rready = sel ? m0_bus.rready : 1'b0;
    m1_bus.rready = sel ? 1'b0 : m1_bus.rready;
    if (!hs) check_val({nm, "_r_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic m0_read(input logic [2:0] idx, input int rdly);
    m0_bus.arvalid = 1'b1;
    m0_bus.araddr  = addr_of(idx);
    rd_phase(1'b0, idx, rdly);
  endtask

  task automatic m1_op(input bit do_wr, input bit do_rd, input logic [2:0] widx, input logic [2:0] ridx,
                       input logic [31:0] wd, input logic [3:0] ws, input int bdly, input int rdly);
    bit aw_done, w_done, b_done, hs_aw, hs_w;
    int n;
    if (do_rd) begin m1_bus.arvalid = 1'b1; m1_bus.araddr = addr_of(ridx); end
    if (do_wr) begin
      m1_bus.awvalid = 1'b1; m1_bus.awaddr = addr_of(widx);
      m1_bus.wvalid = 1'b1; m1_bus.wdata = wd; m1_bus.wstrb = {4'h0, ws};
      aw_done = 1'b0; w_done = 1'b0; n = 0;
      while (!(aw_done && w_done) && n < 300) begin
        @(negedge clk);
        if (do_rd) check_val("m1_rd_waits_wr", 64'(m1_bus.arready), 64'd0);
        hs_aw = m1_bus.awvalid && m1_bus.awready;
        hs_w  = m1_bus.wvalid && m1_bus.wready;
        @(posedge clk); #1; n++;
        if (hs_aw) begin m1_bus.awvalid = 1'b0; m1_bus.awaddr = 32'd0; aw_done = 1'b1; end
        if (hs_w)  begin m1_bus.wvalid = 1'b0; m1_bus.wdata = 32'd0; m1_bus.wstrb = 8'h00; w_done = 1'b1; end
      end
      check_val("m1_aw_w_hs", 64'({aw_done, w_done}), 64'd3);
      b_done = 1'b0; n = 0;
      while (!b_done && n < 300) begin
        if (n >= bdly) m1_bus.bready = 1'b1;
        @(negedge clk);
        if (do_rd) check_val("m1_rd_waits_b", 64'(m1_bus.arready), 64'd0);
        if (m1_bus.bvalid && m1_bus.bready) begin
          b_done = 1'b1;
          check_val("m1_bresp", 64'(m1_bus.bresp), (widx == 3'd6) ? 64'd2 : 64'd0);
          for (int b = 0; b < 4; b++)
            if (ws[b]) ref_mem[widx][8*b +: 8] = wd[8*b +: 8];
        end
        @(posedge clk); #1; n++;
      end
      m1_bus.bready = 1'b0;
      if (!b_done) check_val("m1_b_timeout", 64'd0, 64'd1);
    end
    if (do_rd) rd_phase(1'b1, ridx, rdly);
  endtask

  initial begin : main
    int n;
    logic [2:0] a;
    for (int i = 0; i < 8; i++) begin
      sram_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      ref_mem[i]  = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    end
    m0_bus.arvalid = 1'b0; m0_bus.araddr = 32'd0; m0_bus.rready = 1'b0;
    m0_bus.awvalid = 1'b0; m0_bus.awaddr = 32'd0; m0_bus.wvalid = 1'b0;
    m0_bus.wdata = 32'd0; m0_bus.wstrb = 8'h00; m0_bus.bready = 1'b0;
    m1_bus.arvalid = 1'b0; m1_bus.araddr = 32'd0; m1_bus.rready = 1'b0;
    m1_bus.awvalid = 1'b0; m1_bus.awaddr = 32'd0; m1_bus.wvalid = 1'b0;
    m1_bus.wdata = 32'd0; m1_bus.wstrb = 8'h00; m1_bus.bready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_grant", 64'(grant), 64'd0);
    check_val("reset_outs", 64'({s_bus.arvalid, s_bus.awvalid, s_bus.wvalid, s_bus.rready, s_bus.bready,
                                 m0_bus.arready, m1_bus.arready, m1_bus.awready, m1_bus.wready}), 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    m0_read(3'd0, 2);
    m1_op(1'b1, 1'b0, 3'd4, 3'd0, 32'hDEAD_BEEF, 4'hF, 1, 0);
    // Simultaneous reads from both masters.
    m0_bus.arvalid = 1'b1; m0_bus.araddr = addr_of(3'd1);
    m1_bus.arvalid = 1'b1; m1_bus.araddr = addr_of(3'd2);
    fork
      rd_phase(1'b0, 3'd1, 0);
      rd_phase(1'b1, 3'd2, 0);
    join
    m1_op(1'b1, 1'b1, 3'd5, 3'd5, 32'h1234_5678, 4'h5, 0, 1);
    // M0 stalls rready for 10 cycles while M1 waits.
    m0_bus.arvalid = 1'b1; m0_bus.araddr = addr_of(3'd3);
    fork
      rd_phase(1'b0, 3'd3, 10);
      begin
        @(posedge clk); #1;
        m1_bus.arvalid = 1'b1; m1_bus.araddr = addr_of(3'd7);
        rd_phase(1'b1, 3'd7, 0);
      end
    join

    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        m0_read(3'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        n = int'($urandom_range(0, 2));
        a = 3'($urandom_range(0, 7));
        m1_op(n != 0, n != 1, a, (n == 2) ? a : 3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    join

    // Reset asserted while a write holds the grant.
    hold_slave = 1'b1;
    m1_bus.awvalid = 1'b1; m1_bus.awaddr = addr_of(3'd2);
    m1_bus.wvalid = 1'b1; m1_bus.wdata = 32'hCAFE_F00D; m1_bus.wstrb = 8'h0F;
    n = 0;
    do begin @(negedge clk); n++; end while (grant != 2'b11 && n < 20);
    check_val("wr_grant_before_rst", 64'(grant), 64'd3);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_grant", 64'(grant), 64'd0);
    check_val("async_rst_outs", 64'({m1_bus.awready, m1_bus.wready, m1_bus.bvalid, s_bus.awvalid,
                                     s_bus.wvalid, (|s_bus.awaddr), (|s_bus.wdata), s_bus.bready}), 64'd0);
    m1_bus.awvalid = 1'b0; m1_bus.awaddr = 32'd0; m1_bus.wvalid = 1'b0;
    m1_bus.wdata = 32'd0; m1_bus.wstrb = 8'h00;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; hold_slave = 1'b0;
    m0_bus.arvalid = 1'b1; m0_bus.araddr = addr_of(3'd2);
    m1_bus.arvalid = 1'b1; m1_bus.araddr = addr_of(3'd6);
    @(negedge clk);
    check_val("post_rst_decide", 64'(grant), 64'd0);
    @(negedge clk);
    check_val("post_rst_m0_first", 64'(grant), 64'd1);
    @(posedge clk); #1;
    fork
      rd_phase(1'b0, 3'd2, 0);
      rd_phase(1'b1, 3'd6, 0);
    join
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
